// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - 8N1 serial receiver with 3-sample majority vote and a one-cycle FIFO write strobe
module uart_rx_sampler #(
    parameter  int CLKS_PER_BIT = 347,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       newrxstrobe,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        QUIET,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_n;
    logic             sync1, sync2;
    logic [2:0]       hist;
    logic             vote;
    logic [CNT_W-1:0] timer, timer_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shreg, shreg_n;
    logic [7:0]       rxbyte_n;
    logic             strobe_n, ferr_n;

    assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    assign busy = (state == START) || (state == DATA) || (state == STOP);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 3'b111;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            hist  <= {hist[1:0], sync2};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= QUIET;
            timer       <= '0;
            idx         <= '0;
            shreg       <= '0;
            rxbyte      <= '0;
            newrxstrobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            rxbyte      <= rxbyte_n;
            newrxstrobe <= strobe_n;
            frame_err   <= ferr_n;
        end
    end

    always_comb begin
        state_n  = state;
        timer_n  = timer;
        idx_n    = idx;
        shreg_n  = shreg;
        rxbyte_n = rxbyte;
        strobe_n = 1'b0;
        ferr_n   = 1'b0;
        case (state)
            // Timer counts up here: the line must stay high for a full bit time before we trust it.
            QUIET: begin
                if (!sync2) begin
                    timer_n = '0;
                end else if (timer == BIT_LAST) begin
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            IDLE: begin
                if (!sync2) begin
                    timer_n = HALF_LOAD;
                    state_n = START;
                end
            end
            START: begin
                if (timer != '0) begin
                    timer_n = timer - 1'b1;
                end else if (!vote) begin
                    timer_n = BIT_LAST;
                    idx_n   = '0;
                    state_n = DATA;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (timer != '0) begin
                    timer_n = timer - 1'b1;
                end else begin
                    shreg_n = {vote, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    timer_n = BIT_LAST;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (timer != '0) begin
                    timer_n = timer - 1'b1;
                end else if (vote) begin
                    rxbyte_n = shreg;
                    strobe_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    ferr_n  = 1'b1;
                    timer_n = '0;
                    state_n = QUIET;
                end
            end
            default: begin
                timer_n = '0;
                state_n = QUIET;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - directed and randomized frames checked against a byte-queue reference
module tb_uart_rx_sampler;

    localparam int CPB = 347;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rxbyte;
    logic       newrxstrobe;
    logic       frame_err;
    logic       busy;

    uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx          (rx),
        .rxbyte      (rxbyte),
        .newrxstrobe (newrxstrobe),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] got_b[$];
    int         got_c[$];
    logic [7:0] exp_b[$];
    int         ferr_cnt = 0;
    int         exp_ferr = 0;
    logic       busy_seen = 1'b0;
    logic       rst_q = 1'b0, rst_q2 = 1'b0;
    logic       prev_ev = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    int         fall_cyc = 0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        rst_q  <= resetn;
        rst_q2 <= rst_q;
    end

    // Output monitor: collects strobed bytes and checks pulse/stability rules outside reset.
    always @(negedge clk) begin
        if (newrxstrobe) begin
            got_b.push_back(rxbyte);
            got_c.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (busy) busy_seen = 1'b1;
        if (rst_q && rst_q2) begin
            if (newrxstrobe || frame_err) begin
                checks++;
                assert (!(newrxstrobe && frame_err) && !prev_ev) else begin
                    failures++;
                    $error("FAIL pulse_rule strobe=%0b ferr=%0b prev_pulse=%0b required isolated pulse", newrxstrobe, frame_err, prev_ev);
                end
            end else begin
                checks++;
                assert (rxbyte === prev_byte) else begin
                    failures++;
                    $error("FAIL rxbyte_stable observed=%02h expected=%02h", rxbyte, prev_byte);
                end
            end
        end
        prev_ev   = newrxstrobe || frame_err;
        prev_byte = rxbyte;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_range(input string tag, input int got, input int lo, input int hi);
        checks++;
        assert (got >= lo && got <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int per, input logic stopv, input bit glitch);
        logic v;
        fall_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            v = (i == 0) ? 1'b0 : (i == 9) ? stopv : b[i-1];
            if (glitch && i >= 1 && i <= 8) begin
                hold(v, per / 2 - 3);
                hold(~v, 1);
                hold(v, per - per / 2 + 2);
            end else begin
                hold(v, per);
            end
        end
        rx = 1'b1;
    endtask

    task automatic check_bytes(input string tag, input int n0);
        check({tag, "_count"}, got_b.size(), exp_b.size());
        for (int i = n0; i < got_b.size() && i < exp_b.size(); i++)
            check({tag, "_byte"}, got_b[i], exp_b[i]);
        check({tag, "_ferr"}, ferr_cnt, exp_ferr);
    endtask

    initial begin
        int n0;
        int k;
        logic [7:0] rb;
        int per;

        @(negedge clk);
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_rxbyte", rxbyte, 8'h00);
        check("rst_strobe", newrxstrobe, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        resetn = 1'b1;
        hold(1'b1, CPB + 5);

        n0 = got_b.size();
        send_frame(8'h55, CPB, 1'b1, 1'b0);
        exp_b.push_back(8'h55);
        hold(1'b1, 300);
        check_bytes("first_55", n0);
        if (got_c.size() > n0) check_range("latency", got_c[n0] - fall_cyc, 3298, 3300);

        n0 = got_b.size();
        send_frame(8'h00, CPB, 1'b1, 1'b0);
        send_frame(8'hFF, CPB, 1'b1, 1'b0);
        send_frame(8'hA5, CPB, 1'b1, 1'b0);
        exp_b.push_back(8'h00);
        exp_b.push_back(8'hFF);
        exp_b.push_back(8'hA5);
        hold(1'b1, 300);
        check_bytes("b2b", n0);
        if (got_c.size() >= n0 + 3) begin
            check_range("b2b_space1", got_c[n0+1] - got_c[n0], 10 * CPB - 1, 10 * CPB + 1);
            check_range("b2b_space2", got_c[n0+2] - got_c[n0+1], 10 * CPB - 1, 10 * CPB + 1);
        end

        n0 = got_b.size();
        busy_seen = 1'b0;
        hold(1'b0, 100);
        rx = 1'b1;
        k = 0;
        while (busy && k < 175) begin
            @(negedge clk);
            k++;
        end
        check("glitch_busy_seen", busy_seen, 1'b1);
        check("glitch_busy_clear", busy, 1'b0);
        hold(1'b1, 400);
        check_bytes("start_glitch", n0);

        n0 = got_b.size();
        send_frame(8'h3C, CPB, 1'b1, 1'b1);
        exp_b.push_back(8'h3C);
        hold(1'b1, 300);
        check_bytes("vote_3c", n0);

        n0 = got_b.size();
        send_frame(8'hA5, CPB, 1'b0, 1'b0);
        exp_ferr++;
        hold(1'b1, 100);
        check_bytes("bad_stop", n0);
        check("bad_stop_hold", rxbyte, 8'h3C);
        hold(1'b0, 50);
        hold(1'b1, 400);
        check_bytes("quiet_ignore", n0);
        send_frame(8'h3C, CPB, 1'b1, 1'b0);
        exp_b.push_back(8'h3C);
        hold(1'b1, 300);
        check_bytes("after_err", n0);

        n0 = got_b.size();
        hold(1'b0, CPB * 5 + CPB / 2);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_rxbyte", rxbyte, 8'h00);
        check("midrst_strobe", newrxstrobe, 1'b0);
        check("midrst_ferr", frame_err, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rx = 1'b1;
        resetn = 1'b1;
        hold(1'b1, CPB + 20);
        send_frame(8'h81, CPB, 1'b1, 1'b0);
        exp_b.push_back(8'h81);
        hold(1'b1, 300);
        check_bytes("after_rst", n0);

        n0 = got_b.size();
        send_frame(8'h5A, 340, 1'b1, 1'b0);
        hold(1'b1, 300);
        send_frame(8'h5A, 354, 1'b1, 1'b0);
        exp_b.push_back(8'h5A);
        exp_b.push_back(8'h5A);
        hold(1'b1, 300);
        check_bytes("baud_tol", n0);

        n0 = got_b.size();
        for (int i = 0; i < 6; i++) begin
            rb  = 8'($urandom);
            per = $urandom_range(340, 354);
            send_frame(rb, per, 1'b1, 1'b0);
            exp_b.push_back(rb);
            hold(1'b1, $urandom_range(0, 40));
        end
        hold(1'b1, 300);
        check_bytes("random", n0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
